// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
//   state_t   : controller state (IDLE, RUN, DONE), 2-bit encoding
//   DEF_WIDTH : default operand width
//   CNT_W     : bit-counter width for the default operand width
//   cnt_width : bit-counter width for an arbitrary operand width
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int CNT_W     = $clog2(DEF_WIDTH);

    function automatic int cnt_width(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle for serial_add_ctrl.
//   master : drives start/sub/cin/a/b, observes busy/done/sum/cout/overflow
//   slave  : the sequencer side
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             overflow;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, overflow
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, overflow
    );
endinterface

// File: rtl/serial_add_ctrl_fa_cell.sv
// Combinational 1-bit full adder: the single arithmetic cell the sequencer
// time-shares across all operand bits.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer. Latches a/b on an accepted start, then
// feeds one bit pair per clock (LSB first) through fa_cell, recirculating the
// carry in a flip-flop. Result, carry-out and signed overflow are presented
// with a one-cycle done pulse after WIDTH RUN cycles.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of serial_add_ctrl_if (start/sub/cin/a/b in,
//                busy/done/sum/cout/overflow out)
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);
    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh, b_sh, sum_r;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic             busy_r, done_r, cout_r, ovf_r;
    logic             fa_s, fa_co;
    logic             accept;

    fa_cell u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // start is only honoured outside RUN; a DONE-cycle start chains directly.
    assign accept = bus.start && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            sum_r  <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (accept) begin
                // Subtract is a + ~b + 1, so the inverted operand and forced
                // carry-in are set up once here and the cell never knows.
                a_sh   <= bus.a;
                b_sh   <= bus.sub ? ~bus.b : bus.b;
                carry  <= bus.sub ? 1'b1 : bus.cin;
                cnt    <= '0;
                sum_r  <= '0;
                cout_r <= 1'b0;
                ovf_r  <= 1'b0;
                busy_r <= 1'b1;
                state  <= RUN;
            end else begin
                case (state)
                    RUN: begin
                        a_sh  <= a_sh >> 1;
                        b_sh  <= b_sh >> 1;
                        sum_r <= {fa_s, sum_r[WIDTH-1:1]};
                        carry <= fa_co;
                        cnt   <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            // carry still holds the carry into the MSB here.
                            cout_r <= fa_co;
                            ovf_r  <= carry ^ fa_co;
                            busy_r <= 1'b0;
                            done_r <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy     = busy_r;
    assign bus.done     = done_r;
    assign bus.sum      = sum_r;
    assign bus.cout     = cout_r;
    assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Bench for serial_add_ctrl: an 8-bit and a 13-bit instance share one clock.
// Directed vectors run on the 8-bit instance with literal expectations; a
// per-cycle monitor compares both instances against an arithmetic model.
module tb_serial_add_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_add_ctrl_if #(.WIDTH(8))  if8 ();
    serial_add_ctrl_if #(.WIDTH(13)) if13 ();

    serial_add_ctrl #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    serial_add_ctrl #(.WIDTH(13)) dut13 (.clk(clk), .rst_n(rst_n), .bus(if13));

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: modular sum plus signed-range overflow test on the operands
    // actually added (b or ~b, plus carry-in).
    function automatic void ref_op(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic ci, input logic sb,
                                   output logic [63:0] s, output logic co, output logic ov);
        longint m, av, bv, c, full, half, sa, sbv, t;
        m    = (longint'(1) << w) - 1;
        av   = longint'(a) & m;
        bv   = sb ? (~longint'(b) & m) : (longint'(b) & m);
        c    = sb ? 1 : (ci ? 1 : 0);
        full = av + bv + c;
        s    = 64'(full & m);
        co   = ((full >> w) & 1) != 0;
        half = longint'(1) << (w - 1);
        sa   = (av >= half) ? av - (m + 1) : av;
        sbv  = (bv >= half) ? bv - (m + 1) : bv;
        t    = sa + sbv + c;
        ov   = (t >= half) || (t < -half);
    endfunction

    // ---------------- per-cycle model and compare ----------------
    int          wd [2] = '{8, 13};
    int          rem [2];
    logic        ebusy [2], edone [2], ecout [2], eovf [2], pcout [2], povf [2];
    logic [63:0] esum [2], psum [2];

    always @(negedge clk) begin : mon
        logic [63:0] asum, ia, ib;
        logic        abusy, adone, acout, aovf, ist, isub, icin;
        for (int k = 0; k < 2; k++) begin
            if (k == 0) begin
                asum = 64'(if8.sum);  abusy = if8.busy;  adone = if8.done;
                acout = if8.cout;     aovf = if8.overflow;
                ist = if8.start; isub = if8.sub; icin = if8.cin;
                ia = 64'(if8.a); ib = 64'(if8.b);
            end else begin
                asum = 64'(if13.sum); abusy = if13.busy; adone = if13.done;
                acout = if13.cout;    aovf = if13.overflow;
                ist = if13.start; isub = if13.sub; icin = if13.cin;
                ia = 64'(if13.a); ib = 64'(if13.b);
            end
            if (!rst_n) begin
                rem[k] = 0; ebusy[k] = 0; edone[k] = 0;
                esum[k] = '0; ecout[k] = 0; eovf[k] = 0;
            end
            chk($sformatf("w%0d.busy", wd[k]), 64'(abusy), 64'(ebusy[k]));
            chk($sformatf("w%0d.done", wd[k]), 64'(adone), 64'(edone[k]));
            chk($sformatf("w%0d.cout", wd[k]), 64'(acout), 64'(ecout[k]));
            chk($sformatf("w%0d.ovf", wd[k]),  64'(aovf),  64'(eovf[k]));
            if (!ebusy[k]) chk($sformatf("w%0d.sum", wd[k]), asum, esum[k]);
            // Predict the effect of the coming rising edge.
            if (rst_n) begin
                edone[k] = 0;
                if (rem[k] > 0) begin
                    rem[k]--;
                    if (rem[k] == 0) begin
                        ebusy[k] = 0; edone[k] = 1;
                        esum[k] = psum[k]; ecout[k] = pcout[k]; eovf[k] = povf[k];
                    end
                end else if (ist === 1'b1) begin
                    ref_op(wd[k], ia, ib, icin, isub, psum[k], pcout[k], povf[k]);
                    rem[k] = wd[k]; ebusy[k] = 1;
                    esum[k] = '0; ecout[k] = 0; eovf[k] = 0;
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set8(input logic st, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sb);
        if8.start = st; if8.a = a; if8.b = b; if8.cin = ci; if8.sub = sb;
    endtask

    // Counts edges after the accept edge until done is seen (bounded).
    task automatic wait_done(output int n);
        n = 0;
        while (!if8.done && n < 40) begin
            tick();
            n++;
        end
        chk("done_seen", 64'(if8.done), 64'd1);
    endtask

    task automatic op8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input logic ci, input logic sb,
                       input logic [7:0] es, input logic ec, input logic eo);
        int n;
        set8(1'b1, a, b, ci, sb);
        tick();
        set8(1'b0, ~a, ~b, ~ci, ~sb);   // operands only matter at accept
        wait_done(n);
        chk({nm, ".lat"},  64'(n), 64'd8);
        chk({nm, ".sum"},  64'(if8.sum), 64'(es));
        chk({nm, ".cout"}, 64'(if8.cout), 64'(ec));
        chk({nm, ".ovf"},  64'(if8.overflow), 64'(eo));
        tick();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [63:0] ps;
        logic        pc, po;
        int          n;

        set8(1'b0, 8'h0, 8'h0, 1'b0, 1'b0);
        if13.start = 1'b0; if13.a = '0; if13.b = '0; if13.cin = 1'b0; if13.sub = 1'b0;

        // Pin the model to hand-computed values.
        ref_op(8, 64'h3C, 64'h55, 1'b0, 1'b0, ps, pc, po);
        chk("model.add", {ps[7:0], 6'b0, pc, po}, {8'h91, 6'b0, 1'b0, 1'b1});
        ref_op(8, 64'h80, 64'h01, 1'b0, 1'b1, ps, pc, po);
        chk("model.sub", {ps[7:0], 6'b0, pc, po}, {8'h7F, 6'b0, 1'b1, 1'b1});
        ref_op(13, 64'h1FFF, 64'h0001, 1'b0, 1'b0, ps, pc, po);
        chk("model.w13", {ps[12:0], 1'b0, pc, po}, {13'h0000, 1'b0, 1'b1, 1'b0});

        repeat (3) tick();
        chk("rst.w8",  {if8.busy, if8.done, if8.cout, if8.overflow, 8'(if8.sum)}, 12'h0);
        chk("rst.w13", {if13.busy, if13.done, if13.cout, if13.overflow, 13'(if13.sum)}, 17'h0);
        rst_n = 1'b1;
        tick();

        op8("add",    8'h3C, 8'h55, 1'b0, 1'b0, 8'h91, 1'b0, 1'b1);
        op8("wrap",   8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
        op8("wrapc",  8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
        op8("sub",    8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
        op8("subovf", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // start during RUN is ignored; start in DONE chains.
        set8(1'b1, 8'h3C, 8'h55, 1'b0, 1'b0);
        tick();
        set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(); tick();
        set8(1'b1, 8'hAA, 8'h11, 1'b1, 1'b1);
        tick();
        set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        wait_done(n);
        chk("ign.lat", 64'(n + 3), 64'd8);
        chk("ign.sum", 64'(if8.sum), 64'h91);
        chk("ign.ovf", 64'(if8.overflow), 64'd1);
        set8(1'b1, 8'h01, 8'h02, 1'b0, 1'b0);
        tick();
        chk("b2b.busy", 64'(if8.busy), 64'd1);
        chk("b2b.sum0", 64'(if8.sum), 64'h0);
        set8(1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0);
        wait_done(n);
        chk("b2b.lat", 64'(n + 1), 64'd9);
        chk("b2b.sum", 64'(if8.sum), 64'h03);
        tick();

        // Asynchronous reset mid-RUN discards the operation.
        set8(1'b1, 8'h12, 8'h34, 1'b0, 1'b0);
        tick();
        set8(1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
        tick(); tick(); tick();
        rst_n = 1'b0;
        #1;
        chk("arst.busy", 64'(if8.busy), 64'd0);
        chk("arst.outs", {if8.done, if8.cout, if8.overflow, 8'(if8.sum)}, 11'h0);
        tick(); tick();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("arst.nodone", 64'(if8.done), 64'd0);
        end
        op8("post", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

        // Random operations on both widths; the monitor does the checking.
        for (int i = 0; i < 1000; i++) begin
            set8(1'b1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if13.start = 1'b1;
            if13.a = 13'($urandom); if13.b = 13'($urandom);
            if13.cin = 1'($urandom); if13.sub = 1'($urandom);
            tick();
            set8(1'b0, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
            if13.start = 1'b0;
            if13.a = 13'($urandom); if13.b = 13'($urandom);
            n = 0;
            while ((if8.busy || if13.busy) && n < 40) begin
                tick();
                n++;
            end
            chk("rand.idle", 64'(if8.busy | if13.busy), 64'd0);
            if ($urandom_range(0, 1) == 1) tick();
        end
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
